// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_pkg
// Brief   : Shared types and constants for the register-file writeback buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         NUM_REGS  = 16;
  localparam int         WB_DATA_W = 32;

  typedef struct packed {
    logic                 live;
    logic [3:0]           addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [3:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
//------------------------------------------------------------------------------
// Module  : wb_fifo
// Brief   : Load queue with per-entry live bit, address-match kill and a
//           pending-destination bitmap built from live entries.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = WB_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                i_clk_w,
  input  logic                i_rst_n_w,
  input  logic                i_push_w,
  input  wb_req_t             i_push_req_w,
  input  logic                i_pop_w,
  input  logic                i_kill_w,
  input  logic [3:0]          i_kill_addr_w,
  output wb_req_t             o_head_w,
  output logic [CNT_W-1:0]    o_count_w,
  output logic [NUM_REGS-1:0] o_live_mask_w
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Popping clears the live bit so vacated slots never leak into the mask.
  always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
    if (!i_rst_n_w) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_kill_w) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].addr == i_kill_addr_w) r_mem[i].live <= 1'b0;
        end
      end
      if (i_pop_w) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + PTR_W'(1);
      end
      if (i_push_w) begin
        r_mem[r_tail] <= i_push_req_w;
        r_tail        <= r_tail + PTR_W'(1);
      end
      case ({i_push_w, i_pop_w})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_live_mask_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live) o_live_mask_w = o_live_mask_w | addr_onehot(r_mem[i].addr);
    end
  end

  assign o_head_w  = r_mem[r_head];
  assign o_count_w = r_count;

endmodule

`default_nettype wire

// File: rtl/writeback_buffer.sv
//------------------------------------------------------------------------------
// Module  : writeback_buffer
// Brief   : Merges ALU results and queued load data into one registered
//           register-file write stream; R15 goes to a PC-write strobe.
//           Optional macro WB_LOAD_BYPASS_EN: idle-path loads skip the queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_buffer
  import wb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = WB_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                i_clk_w,
  input  logic                i_rst_n_w,
  input  logic                i_alu_valid_w,
  input  logic [3:0]          i_alu_addr_w,
  input  logic [DATA_W-1:0]   i_alu_data_w,
  input  logic                i_ld_valid_w,
  output logic                o_ld_ready_w,
  input  logic [3:0]          i_ld_addr_w,
  input  logic [DATA_W-1:0]   i_ld_data_w,
  output logic                o_reg_write_w,
  output logic [3:0]          o_write_addr_w,
  output logic [DATA_W-1:0]   o_write_data_w,
  output logic                o_pc_write_w,
  output logic [DATA_W-1:0]   o_pc_data_w,
  output logic [NUM_REGS-1:0] o_pending_mask_w,
  output logic [CNT_W-1:0]    o_count_w
);

  logic              w_ld_fire;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_q_empty;
  wb_req_t           w_head;
  wb_req_t           w_push_req;
  wb_req_t           w_sel;

  logic              r_reg_write;
  logic [3:0]        r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic              r_pc_write;
  logic [DATA_W-1:0] r_pc_data;

  assign o_ld_ready_w = (o_count_w < CNT_W'(DEPTH));
  assign w_ld_fire    = i_ld_valid_w && o_ld_ready_w;
  assign w_q_empty    = (o_count_w == '0);

`ifdef WB_LOAD_BYPASS_EN
  assign w_bypass = !i_alu_valid_w && w_q_empty && w_ld_fire;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ld_fire && !w_bypass;
  assign w_pop  = !i_alu_valid_w && !w_q_empty;

  // A same-cycle load to the ALU's destination is older, so it enters already dead.
  assign w_push_req = '{live: !(i_alu_valid_w && (i_alu_addr_w == i_ld_addr_w)),
                        addr: i_ld_addr_w,
                        data: i_ld_data_w};

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk_w       (i_clk_w),
    .i_rst_n_w     (i_rst_n_w),
    .i_push_w      (w_push),
    .i_push_req_w  (w_push_req),
    .i_pop_w       (w_pop),
    .i_kill_w      (i_alu_valid_w),
    .i_kill_addr_w (i_alu_addr_w),
    .o_head_w      (w_head),
    .o_count_w     (o_count_w),
    .o_live_mask_w (o_pending_mask_w)
  );

  always_comb begin
    w_sel = '0;
    if (i_alu_valid_w) begin
      w_sel = '{live: 1'b1, addr: i_alu_addr_w, data: i_alu_data_w};
    end else if (!w_q_empty) begin
      w_sel = w_head;
    end else if (w_bypass) begin
      w_sel = '{live: 1'b1, addr: i_ld_addr_w, data: i_ld_data_w};
    end
  end

  always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
    if (!i_rst_n_w) begin
      r_reg_write  <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_pc_write   <= 1'b0;
      r_pc_data    <= '0;
    end else begin
      r_reg_write <= w_sel.live && (w_sel.addr != REG_PC);
      r_pc_write  <= w_sel.live && (w_sel.addr == REG_PC);
      if (w_sel.live && (w_sel.addr != REG_PC)) begin
        r_write_addr <= w_sel.addr;
        r_write_data <= w_sel.data;
      end
      if (w_sel.live && (w_sel.addr == REG_PC)) r_pc_data <= w_sel.data;
    end
  end

  assign o_reg_write_w  = r_reg_write;
  assign o_write_addr_w = r_write_addr;
  assign o_write_data_w = r_write_data;
  assign o_pc_write_w   = r_pc_write;
  assign o_pc_data_w    = r_pc_data;

endmodule

`default_nettype wire
